// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle radix-2 signed shift-add multiplier controller
// for the EX-stage MUL. It stalls the pipeline while iterating and returns the
// low WIDTH bits of A*B with a one-cycle Done pulse.
module mul_sequencer #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_EXIT = 1'b0
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Stall,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic             sign;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier_next;
    logic             last_iter;

    // Operand magnitudes, next-iteration datapath values and the stall/busy decode
    always_comb begin
        accept      = Start & ~Flush & ((state == IDLE) | (state == DONE));
        a_mag       = A[WIDTH-1] ? -A : A;
        b_mag       = B[WIDTH-1] ? -B : B;
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mplier_next = mplier >> 1;
        last_iter   = (cnt == CW'(WIDTH - 1)) | (EARLY_EXIT & (mplier_next == '0));
        Stall       = accept | (state == CALC) | (state == FIX);
        Busy        = (state != IDLE);
    end

    // Sequencer FSM with registered Done/Result; Flush aborts from any state
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            sign   <= 1'b0;
            cnt    <= '0;
            Done   <= 1'b0;
            Result <= '0;
        end else if (Flush) begin
            state <= IDLE;
            Done  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        sign   <= A[WIDTH-1] ^ B[WIDTH-1];
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= (EARLY_EXIT && (B == '0)) ? FIX : CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier_next;
                    cnt    <= cnt + CW'(1);
                    if (last_iter) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    Result <= sign ? -acc : acc;
                    Done   <= 1'b1;
                    state  <= DONE;
                end
                default: begin
                    state <= IDLE;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer: a WIDTH=32 full-latency
// instance and a WIDTH=32 early-exit instance sharing clock, reset and operands.
module tb_mul_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start0;
    logic        start1;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall0, busy0, done0;
    logic [31:0] result0;
    logic        stall1, busy1, done1;
    logic [31:0] result1;

    int checks   = 0;
    int failures = 0;

    mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
        .Clk(clk), .Reset_n(reset_n), .Start(start0), .Flush(flush),
        .A(a), .B(b), .Stall(stall0), .Busy(busy0), .Done(done0), .Result(result0)
    );

    mul_sequencer #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
        .Clk(clk), .Reset_n(reset_n), .Start(start1), .Flush(flush),
        .A(a), .B(b), .Stall(stall1), .Busy(busy1), .Done(done1), .Result(result1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Full-latency op on dut0: Start in cycle 0, Done expected in cycle 34
    task automatic run0(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp);
        a = av; b = bv; start0 = 1'b1;
        #1;
        chk("stall_c0", {31'b0, stall0}, 32'd1);
        chk("busy_c0", {31'b0, busy0}, 32'd0);
        next();
        start0 = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            chk("stall_calc", {31'b0, stall0}, 32'd1);
            chk("done_early", {31'b0, done0}, 32'd0);
            next();
        end
        chk("done_c34", {31'b0, done0}, 32'd1);
        chk("result", result0, exp);
        chk("stall_c34", {31'b0, stall0}, 32'd0);
        next();
        chk("done_c35", {31'b0, done0}, 32'd0);
        chk("busy_c35", {31'b0, busy0}, 32'd0);
    endtask

    // Early-exit op on dut1: Done expected in cycle n
    task automatic run1(input logic [31:0] av, input logic [31:0] bv, input int n,
                        input logic [31:0] exp);
        a = av; b = bv; start1 = 1'b1;
        #1;
        chk("ee_stall_c0", {31'b0, stall1}, 32'd1);
        next();
        start1 = 1'b0;
        for (int c = 1; c < n; c++) begin
            chk("ee_stall", {31'b0, stall1}, 32'd1);
            chk("ee_done_early", {31'b0, done1}, 32'd0);
            next();
        end
        chk("ee_done", {31'b0, done1}, 32'd1);
        chk("ee_result", result1, exp);
        next();
        chk("ee_done_after", {31'b0, done1}, 32'd0);
        chk("ee_busy_after", {31'b0, busy1}, 32'd0);
    endtask

    initial begin
        logic seen;
        reset_n = 1'b0; start0 = 1'b0; start1 = 1'b0; flush = 1'b0;
        a = '0; b = '0;
        next();
        next();
        chk("rst_stall", {31'b0, stall0}, 32'd0);
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_done", {31'b0, done0}, 32'd0);
        chk("rst_result", result0, 32'd0);
        chk("rst_busy1", {31'b0, busy1}, 32'd0);
        reset_n = 1'b1;
        next();

        run0(32'd3, 32'd5, 32'd15);
        run0(32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6);
        run0(32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd16);
        run0(32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        run0(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run0(32'd4, 32'd5, 32'd20);

        // Flush mid-operation: Result keeps 20, Done never pulses
        a = 32'd9; b = 32'd9; start0 = 1'b1;
        next();
        start0 = 1'b0;
        for (int c = 1; c < 10; c++) next();
        flush = 1'b1;
        next();
        flush = 1'b0;
        chk("flush_busy", {31'b0, busy0}, 32'd0);
        chk("flush_stall", {31'b0, stall0}, 32'd0);
        chk("flush_result", result0, 32'd20);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            seen = seen | done0;
            next();
        end
        chk("flush_no_done", {31'b0, seen}, 32'd0);

        // Start and Flush together: nothing starts
        a = 32'd7; b = 32'd7; start0 = 1'b1; flush = 1'b1;
        #1;
        chk("sf_stall", {31'b0, stall0}, 32'd0);
        next();
        chk("sf_busy", {31'b0, busy0}, 32'd0);
        chk("sf_stall2", {31'b0, stall0}, 32'd0);
        start0 = 1'b0; flush = 1'b0;
        next();

        // Back-to-back with Start held; operand change after the Start edge is ignored
        a = 32'hFFFF_FFFD; b = 32'd5; start0 = 1'b1;
        next();
        a = 32'd2; b = 32'd3;
        for (int c = 1; c <= 33; c++) begin
            chk("b2b_stall", {31'b0, stall0}, 32'd1);
            chk("b2b_done_early", {31'b0, done0}, 32'd0);
            next();
        end
        chk("b2b_done1", {31'b0, done0}, 32'd1);
        chk("b2b_result1", result0, 32'hFFFF_FFF1);
        chk("b2b_stall_accept", {31'b0, stall0}, 32'd1);
        next();
        start0 = 1'b0;
        for (int c = 35; c <= 67; c++) begin
            chk("b2b_stall2", {31'b0, stall0}, 32'd1);
            chk("b2b_done2_early", {31'b0, done0}, 32'd0);
            next();
        end
        chk("b2b_done2", {31'b0, done0}, 32'd1);
        chk("b2b_result2", result0, 32'd6);
        next();
        chk("b2b_idle", {31'b0, busy0}, 32'd0);

        // Asynchronous reset in cycle 15 of an op
        a = 32'd7; b = 32'd7; start0 = 1'b1;
        next();
        start0 = 1'b0;
        for (int c = 1; c < 15; c++) next();
        chk("pre_rst_busy", {31'b0, busy0}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_stall", {31'b0, stall0}, 32'd0);
        chk("arst_busy", {31'b0, busy0}, 32'd0);
        chk("arst_done", {31'b0, done0}, 32'd0);
        chk("arst_result", result0, 32'd0);
        #1 reset_n = 1'b1;
        next();

        // Early-exit instance
        run1(32'd3, 32'd2, 4, 32'd6);
        run1(32'd3, 32'd0, 2, 32'd0);
        run1(32'hFFFF_FFFB, 32'd8, 6, 32'hFFFF_FFD8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle controller for the EX-stage MUL operation (ALUControl 6'b011000).
- Accepts a start request from the EX-stage control, runs a radix-2 signed shift-add multiply over several cycles, and stalls the pipeline until the result is ready.
- Returns the low WIDTH bits of the product, which is the MIPS MUL result, for writeback through the normal ALU result mux.

Parameters:
- WIDTH, 32, operand and result width in bits.
- EARLY_EXIT, 0, when set to 1, terminates iteration once the remaining multiplier magnitude is zero.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a multiply. Asserted by EX control while ALUControl==6'b011000 and the instruction is valid.
- Flush  input  1  abort any operation in flight (branch/jump squash of EX).
- A  input  WIDTH  multiplicand (rs), two's complement.
- B  input  WIDTH  multiplier (rt), two's complement.
- Stall  output  1  hold IF/ID/EX pipeline registers.
- Busy  output  1  sequencer is not IDLE.
- Done  output  1  one-cycle pulse; Result is valid this cycle.
- Result  output  WIDTH  low WIDTH bits of A*B.

Behaviour:
- Reset: one clock domain; reset is asynchronous and active-low on Reset_n. On reset the state is IDLE, Stall=0, Busy=0, Done=0, Result=0, and all internal registers are 0.
- States:
  - IDLE: wait for Start.
  - CALC: one iteration per cycle.
  - FIX: sign correction and write of Result.
  - DONE: Done=1 for one cycle.
- IDLE:
  - Start=1 and Flush=0 → latch |A|, |B|, and sign = A[W-1]^B[W-1]; clear accumulator and counter; go to CALC.
  - With EARLY_EXIT=1 and B==0 → go to FIX directly.
- CALC, each cycle:
  - If mplier[0], add mcand to acc (WIDTH-bit, overflow discarded).
  - Shift mcand left by 1 and mplier right by 1 (logical); increment counter.
  - Go to FIX when counter reaches WIDTH-1 after this iteration (WIDTH iterations total).
  - With EARLY_EXIT=1, also go to FIX when the shifted mplier==0.
- FIX: Result ← sign ? -acc : acc (two's complement, low WIDTH bits); go to DONE.
- DONE:
  - Done=1.
  - Start=1 → accept a new operation exactly as in IDLE (back-to-back).
  - Otherwise go to IDLE.
- Latency: Start sampled at edge 0 gives CALC in cycles 1..WIDTH, FIX in cycle WIDTH+1, and Done in cycle WIDTH+2 (34 for WIDTH=32). With EARLY_EXIT=1, CALC lasts until the multiplier is exhausted.
- Stall = (Start & state∈{IDLE,DONE} & ~Flush) | state∈{CALC,FIX}. Stall is combinational, so the pipeline freezes in the same cycle Start rises. It is low in DONE unless a new Start is accepted.
- Busy = (state != IDLE).
- Start while in CALC or FIX is ignored; the held EX instruction keeps it asserted, which is expected.
- Flush:
  - In any state, go to IDLE at the next edge. Done does not assert for the aborted op.
  - Result keeps its previous value.
  - Flush=1 with Start=1 in the same cycle: Flush wins and no operation starts.
- Result changes only on the FIX→DONE edge and holds until the next completed operation.
- Operand changes after the Start edge have no effect; operands are latched.
- Counter width is $clog2(WIDTH). No state other than the four listed is reachable. Any illegal encoding goes to IDLE.

Test Plan:
- Basic multiply (WIDTH=32, EARLY_EXIT=0): A=3, B=5, Start for 1 cycle → Stall high in cycles 0..33, Done=1 in cycle 34 only, Result=15.
- Sign handling: A=-7 (0xFFFFFFF9), B=6 → Result=0xFFFFFFD6. A=-4, B=-4 → Result=16. Both at cycle 34.
- Overflow truncation: A=0x00010000, B=0x00010000 → Result=0x00000000. A=0x80000000, B=-1 → Result=0x80000000.
- Flush mid-operation: Start with A=9, B=9; Flush at cycle 10 → IDLE at cycle 11, Done never pulses, Result keeps its prior value. Also Start and Flush in the same cycle → Busy stays 0 and Stall stays 0.
- Back-to-back and reset: Start held across DONE with new operands 2 and 3 → second Done 34 cycles later with Result=6. Reset_n low at cycle 15 of an op → all outputs 0 immediately, asynchronously.
- EARLY_EXIT=1:
  - A=3, B=2 → CALC in cycles 1..2, FIX in cycle 3, Done in cycle 4, Result=6.
  - B=0 → Done in cycle 2, Result=0.
